// File: rtl/mem_arbiter.sv
// Shares one single-outstanding memory port among NUM_REQ requesters (IDLE/ISSUE/WAIT).
// Round-robin arbitration by default; define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
package bronco_params;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

module mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = bronco_params::ADDR_WIDTH,
  parameter int DATA_WIDTH = bronco_params::DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            r_req_vld,
  output logic [NUM_REQ-1:0]            r_req_rdy,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] r_req_addr,
  output logic [NUM_REQ-1:0]            r_rsp_vld,
  output logic [DATA_WIDTH-1:0]         r_rsp_data,
  output logic                          m_req_vld,
  input  logic                          m_req_rdy,
  output logic [ADDR_WIDTH-1:0]         m_req_addr,
  input  logic                          m_rsp_vld,
  input  logic [DATA_WIDTH-1:0]         m_rsp_data,
  output logic                          busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PW-1:0]         gnt_idx;
  logic                  gnt_any;

  // Winner search; iterating from the far end lets the nearest asserted request overwrite.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = i;
      if (r_req_vld[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
`else
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (r_req_vld[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    r_req_rdy = '0;
    r_rsp_vld = '0;
    m_req_vld = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          r_req_rdy[gnt_idx] = 1'b1;
          owner_d            = gnt_idx;
          addr_d             = r_req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          state_d            = S_ISSUE;
`ifdef MEM_ARB_FIXED_PRIO_EN
          ptr_d              = '0;
`else
          ptr_d              = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`endif
        end
      end
      S_ISSUE: begin
        m_req_vld = 1'b1;
        if (m_req_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        r_rsp_vld[owner_q] = m_rsp_vld;
        if (m_rsp_vld) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are quiet for the whole reset cycle, even though state only clears at the edge.
    if (rst) begin
      r_req_rdy = '0;
      r_rsp_vld = '0;
      m_req_vld = 1'b0;
    end
  end

  assign m_req_addr = addr_q;
  assign r_rsp_data = m_rsp_data;
  assign busy       = (state_q != S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    r_req_vld, r_req_rdy, r_rsp_vld;
  logic [N*AW-1:0] r_req_addr;
  logic [DW-1:0]   r_rsp_data, m_rsp_data;
  logic            m_req_vld, m_req_rdy, m_rsp_vld, busy;
  logic [AW-1:0]   m_req_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .r_req_vld(r_req_vld), .r_req_rdy(r_req_rdy), .r_req_addr(r_req_addr),
    .r_rsp_vld(r_rsp_vld), .r_rsp_data(r_rsp_data),
    .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr),
    .m_rsp_vld(m_rsp_vld), .m_rsp_data(m_rsp_data), .busy(busy)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Transaction-level model: is a request held, has it been sent, who owns it.
  bit            md_have, md_sent;
  int            md_ptr, md_owner;
  logic [AW-1:0] md_addr;
  int            gnt_log[$];

  logic [N-1:0]  obs_rdy, obs_rsp;
  logic          obs_mvld, obs_busy;
  logic [AW-1:0] obs_maddr;
  logic [DW-1:0] obs_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    int r;
    r = -1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
`else
    for (int k = N - 1; k >= 0; k--) if (v[(p + k) % N]) r = (p + k) % N;
`endif
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [N*AW-1:0] pa(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                         input logic [AW-1:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic step(input logic rs, input logic [N-1:0] vld, input logic [N*AW-1:0] addr,
                      input logic mrdy, input logic mrv, input logic [DW-1:0] mrd);
    int g;
    logic [N-1:0] e_rsp;
    @(negedge clk);
    rst = rs; r_req_vld = vld; r_req_addr = addr;
    m_req_rdy = mrdy; m_rsp_vld = mrv; m_rsp_data = mrd;
    #1;
    g     = (!rs && !md_have) ? pick(vld, md_ptr) : -1;
    e_rsp = (!rs && md_have && md_sent && mrv) ? onehot(md_owner) : '0;
    chk("r_req_rdy", 32'(r_req_rdy), 32'(onehot(g)));
    chk("m_req_vld", 32'(m_req_vld), 32'(!rs && md_have && !md_sent));
    if (!rs && md_have && !md_sent) chk("m_req_addr", 32'(m_req_addr), 32'(md_addr));
    chk("r_rsp_vld", 32'(r_rsp_vld), 32'(e_rsp));
    if (|e_rsp) chk("r_rsp_data", 32'(r_rsp_data), 32'(mrd));
    chk("busy", 32'(busy), 32'(!rs && md_have));
    obs_rdy = r_req_rdy; obs_rsp = r_rsp_vld; obs_mvld = m_req_vld;
    obs_busy = busy; obs_maddr = m_req_addr; obs_data = r_rsp_data;
    for (int i = 0; i < N; i++) if (r_req_rdy[i]) gnt_log.push_back(i);
    @(posedge clk);
    if (rs) begin
      md_have = 0; md_sent = 0; md_ptr = 0; md_owner = 0; md_addr = '0;
    end else if (!md_have) begin
      if (g >= 0) begin
        md_have = 1; md_sent = 0; md_owner = g; md_addr = addr[g*AW +: AW];
`ifdef MEM_ARB_FIXED_PRIO_EN
        md_ptr = 0;
`else
        md_ptr = (g + 1) % N;
`endif
      end
    end else if (!md_sent) begin
      if (mrdy) md_sent = 1;
    end else if (mrv) begin
      md_have = 0;
    end
  endtask

  initial begin
    logic [N*AW-1:0] a;
    rst = 1'b1; r_req_vld = '0; r_req_addr = '0;
    m_req_rdy = 1'b0; m_rsp_vld = 1'b0; m_rsp_data = '0;
    md_have = 0; md_sent = 0; md_ptr = 0; md_owner = 0; md_addr = '0;

    // Reset: all request/response outputs quiet.
    step(1, 3'b111, '1, 1, 1, 8'hFF);
    step(1, 3'b000, '0, 0, 0, 8'h00);

    // Single request, 1-cycle memory latency.
    a = pa(16'h10, 16'h0, 16'h0);
    step(0, 3'b001, a, 1, 0, 8'h00);
    chk("single_gnt", 32'(obs_rdy), 32'h1);
    step(0, 3'b000, a, 1, 0, 8'h00);
    chk("single_mvld", 32'(obs_mvld), 32'h1);
    chk("single_addr", 32'(obs_maddr), 32'h10);
    step(0, 3'b000, a, 1, 1, 8'h5A);
    chk("single_rsp", 32'(obs_rsp), 32'h1);
    chk("single_data", 32'(obs_data), 32'h5A);

    // Contention: requesters 0 and 1 hold valid continuously.
    step(1, 3'b000, '0, 0, 0, 8'h00);
    gnt_log.delete();
    a = pa(16'h20, 16'h80, 16'h0);
    for (int t = 0; t < 4; t++) begin
      int eg;
`ifdef MEM_ARB_FIXED_PRIO_EN
      eg = 0;
`else
      eg = t % 2;
`endif
      step(0, 3'b011, a, 1, 0, 8'h00);
      step(0, 3'b011, a, 1, 0, 8'h00);
      chk("cont_addr", 32'(obs_maddr), (eg == 0) ? 32'h20 : 32'h80);
      step(0, 3'b011, a, 1, 1, 8'(8'h30 + t));
      chk("cont_rsp_owner", 32'(obs_rsp), 32'(onehot(eg)));
    end
    chk("cont_ngnt", 32'(gnt_log.size()), 32'd4);
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk("cont_gnt", 32'(gnt_log[t]), 32'd0);
`else
      chk("cont_gnt", 32'(gnt_log[t]), 32'(t % 2));
`endif
    end

    // Backpressure: 3 stalled cycles, then response latency 4.
    a = pa(16'h44, 16'h55, 16'h66);
    step(0, 3'b001, a, 0, 0, 8'h00);
    for (int t = 0; t < 3; t++) begin
      step(0, 3'b111, a, 0, 1, 8'h00);
      chk("bp_mvld", 32'(obs_mvld), 32'h1);
      chk("bp_addr", 32'(obs_maddr), 32'h44);
      chk("bp_rdy", 32'(obs_rdy), 32'h0);
      chk("bp_busy", 32'(obs_busy), 32'h1);
    end
    step(0, 3'b111, a, 1, 0, 8'h00);
    for (int t = 0; t < 3; t++) begin
      step(0, 3'b111, a, 0, 0, 8'h00);
      chk("bp_wait_busy", 32'(obs_busy), 32'h1);
    end
    step(0, 3'b000, a, 0, 1, 8'hA7);
    chk("bp_rsp", 32'(obs_rsp), 32'h1);

    // Reset in WAIT with a late response afterwards.
    step(1, 3'b000, '0, 0, 0, 8'h00);
    a = pa(16'h12, 16'h34, 16'h56);
    step(0, 3'b001, a, 1, 0, 8'h00);
    step(0, 3'b000, a, 1, 0, 8'h00);
    step(1, 3'b000, a, 0, 0, 8'h00);
    step(0, 3'b000, a, 0, 0, 8'h00);
    step(0, 3'b000, a, 0, 1, 8'hEE);
    chk("rstw_rsp", 32'(obs_rsp), 32'h0);
    chk("rstw_busy", 32'(obs_busy), 32'h0);
    step(0, 3'b011, a, 1, 0, 8'h00);
    chk("rstw_gnt", 32'(obs_rdy), 32'h1);
    step(0, 3'b000, a, 1, 0, 8'h00);
    step(0, 3'b000, a, 1, 1, 8'h11);

    // Stray responses in IDLE and in the ISSUE handshake cycle.
    a = pa(16'h0, 16'h99, 16'h0);
    step(0, 3'b000, a, 1, 1, 8'h77);
    chk("stray_idle", 32'(obs_rsp), 32'h0);
    step(0, 3'b010, a, 1, 1, 8'h77);
    step(0, 3'b000, a, 1, 1, 8'h66);
    chk("stray_issue", 32'(obs_rsp), 32'h0);
    step(0, 3'b000, a, 1, 1, 8'hC3);
    chk("stray_legit", 32'(obs_rsp), 32'h2);
    chk("stray_data", 32'(obs_data), 32'hC3);

    // Random traffic, including occasional resets and stray responses.
    for (int t = 0; t < 3000; t++) begin
      step($urandom_range(0, 49) == 0, N'($urandom), (N*AW)'({$urandom, $urandom}),
           1'($urandom), $urandom_range(0, 9) < 4, DW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
